// File: rtl/uart_pkg.sv
// Shared UART timing constants and the feeder's pacing-state encoding.
package uart_pkg;

    localparam int UART_BIT_CLKS   = 26;
    localparam int UART_FRAME_BITS = 10;

    // Two spare cycles on top of a full frame so the transmitter is idle before the next rising edge.
    localparam int FRAME_CLKS_DEF  = UART_BIT_CLKS * UART_FRAME_BITS + 2;
    localparam int DEPTH_LOG2_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STROBE,
        WAIT
    } feeder_state_t;

    function automatic int min_frame_clks();
        return UART_BIT_CLKS * UART_FRAME_BITS;
    endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer-side write strobe plus the paced byte/strobe pair driven towards the UART transmitter.
interface uart_tx_feeder_if #(
  parameter int DEPTH_LOG2 = 4
) ();
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  busy;
  logic                  uart_send;
  logic [7:0]            uart_data_out;
  logic                  ovf;

  modport master (
    output wr_en, wr_data,
    input  full, count, busy, uart_send, uart_data_out, ovf
  );

  modport slave (
    input  wr_en, wr_data,
    output full, count, busy, uart_send, uart_data_out, ovf
  );
endinterface

// File: rtl/sync_fifo_byte.sv
// Byte FIFO with wrapping pointers and registered count/full; head is the word at the read pointer.
// A write presented while full is dropped even if a pop happens in the same cycle.
module sync_fifo_byte #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  input  logic                rd_en,
  output logic [7:0]          head,
  output logic [DEPTH_LOG2:0] count,
  output logic                full
);
  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  push;
  logic                  pop;

  // Acceptance looks at the registered full flag, so a coincident pop cannot rescue a write.
  assign push = wr_en && !full;
  assign pop  = rd_en && (count != '0);
  assign head = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bytes and paces them to a busy-less UART transmitter: one 2-cycle send strobe per FRAME_CLKS.
// Optional sticky overflow flag and saturating drop counter under `UART_TX_FEEDER_OVF_EN.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int FRAME_CLKS = FRAME_CLKS_DEF
) (
  input logic             sys_clk,
  input logic             sys_rst,
  uart_tx_feeder_if.slave bus
);
  localparam int               GAP_W      = $clog2(FRAME_CLKS) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(FRAME_CLKS - 1);
  localparam logic [GAP_W-1:0] STROBE_END = GAP_W'(2);

  if (FRAME_CLKS < min_frame_clks()) begin : g_frame_check
    $error("FRAME_CLKS shorter than one UART frame");
  end

  feeder_state_t       state;
  feeder_state_t       state_nxt;
  logic [GAP_W-1:0]    gap;
  logic [GAP_W-1:0]    gap_nxt;
  logic                send_q;
  logic                send_nxt;
  logic [7:0]          dout_q;
  logic [7:0]          dout_nxt;
  logic                busy_q;
  logic                pop;
  logic [7:0]          fifo_head;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                fifo_full;

  sync_fifo_byte #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state  <= IDLE;
      gap    <= '0;
      send_q <= 1'b0;
      dout_q <= 8'h00;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      gap    <= gap_nxt;
      send_q <= send_nxt;
      dout_q <= dout_nxt;
      busy_q <= (state != IDLE) || (fifo_count != '0);
    end
  end

  // The head byte is captured on the edge entering LOAD and popped on the edge leaving it,
  // so the data bus settles one full cycle before the strobe rises.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap;
    send_nxt  = send_q;
    dout_nxt  = dout_q;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        gap_nxt = '0;
        if (fifo_count != '0) begin
          state_nxt = LOAD;
          dout_nxt  = fifo_head;
        end
      end
      LOAD: begin
        pop       = 1'b1;
        state_nxt = STROBE;
        send_nxt  = 1'b1;
        gap_nxt   = GAP_W'(1);
      end
      STROBE: begin
        gap_nxt = gap + 1'b1;
        if (gap == STROBE_END) begin
          send_nxt  = 1'b0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        gap_nxt = gap + 1'b1;
        if (gap == GAP_LAST) begin
          if (fifo_count != '0) begin
            state_nxt = LOAD;
            dout_nxt  = fifo_head;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.full          = fifo_full;
  assign bus.count         = fifo_count;
  assign bus.busy          = busy_q;
  assign bus.uart_send     = send_q;
  assign bus.uart_data_out = dout_q;

`ifdef UART_TX_FEEDER_OVF_EN
  logic       ovf_q;
  logic [7:0] drop_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ovf_q    <= 1'b0;
      drop_cnt <= 8'h00;
    end else if (bus.wr_en && fifo_full) begin
      ovf_q <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: stimulus pushes expected bytes, a negedge monitor checks each strobe.
module tb_uart_tx_feeder;
  localparam int F = 262;
`ifdef UART_TX_FEEDER_OVF_EN
  localparam bit EXP_OVF = 1'b1;
`else
  localparam bit EXP_OVF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   max_cnt;
  logic [7:0] exp_q[$];
  int         rise_t[$];

  uart_tx_feeder_if #(.DEPTH_LOG2(4)) bus ();

  uart_tx_feeder #(
    .DEPTH_LOG2 (4),
    .FRAME_CLKS (F)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #(100000 * 20);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every strobe rise must carry the next queued byte, held stable since the prior cycle.
  initial begin
    logic       prev_send;
    logic [7:0] prev_data;
    int         hi_len;
    prev_send = 1'b0;
    prev_data = 8'h00;
    hi_len    = 0;
    forever begin
      @(negedge clk);
      if (bus.uart_send === 1'b1 && prev_send === 1'b0) begin
        rise_t.push_back(cyc);
        check("mon_data_stable", int'(bus.uart_data_out), int'(prev_data));
        check("mon_sb_nonempty", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("mon_byte", int'(bus.uart_data_out), int'(exp_q.pop_front()));
        hi_len = 1;
      end else if (bus.uart_send === 1'b1) begin
        hi_len++;
      end else if (prev_send === 1'b1) begin
        check("mon_strobe_width", hi_len, 2);
      end
      prev_send = bus.uart_send;
      prev_data = bus.uart_data_out;
    end
  end

  task automatic drive(input logic [7:0] d, input bit accept);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    if (accept) exp_q.push_back(d);
  endtask

  task automatic release_wr();
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      if (!bus.busy && bus.count == '0) break;
    end
    if (i >= budget) check(name, int'(bus.busy), 0);
  endtask

  task automatic wait_rise(input string name, input int n, input int budget);
    for (int i = 0; i < budget && rise_t.size() < n; i++) @(negedge clk);
    check(name, rise_t.size(), n);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_send"}, int'(bus.uart_send), 0);
    check({tag, "_data"}, int'(bus.uart_data_out), 0);
    check({tag, "_count"}, int'(bus.count), 0);
    check({tag, "_full"}, int'(bus.full), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_ovf"}, int'(bus.ovf), 0);
  endtask

  task automatic single_byte(input string tag, input logic [7:0] d);
    int t;
    int r;
    rise_t.delete();
    drive(d, 1'b1);
    t = cyc + 1;
    release_wr();
    @(negedge clk);
    check({tag, "_data_t1"}, int'(bus.uart_data_out), int'(d));
    check({tag, "_send_t1"}, int'(bus.uart_send), 0);
    @(negedge clk);
    check({tag, "_send_t2"}, int'(bus.uart_send), 1);
    @(negedge clk);
    check({tag, "_send_t3"}, int'(bus.uart_send), 1);
    @(negedge clk);
    check({tag, "_send_t4"}, int'(bus.uart_send), 0);
    wait_idle({tag, "_idle_timeout"}, 2 * F);
    check({tag, "_rises"}, rise_t.size(), 1);
    r = (rise_t.size() > 0) ? rise_t[0] : 0;
    check({tag, "_rise_time"}, r, t + 2);
    check({tag, "_busy_fall"}, cyc - r, F);
  endtask

  initial begin
    int r;
    int sent;
    int guard;
    n_checks    = 0;
    n_pass      = 0;
    max_cnt     = 0;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    single_byte("single", 8'h55);

    // Burst of four consecutive writes.
    rise_t.delete();
    max_cnt = 0;
    for (int i = 1; i <= 4; i++) drive(8'(i), 1'b1);
    release_wr();
    wait_idle("burst_idle_timeout", 6 * F);
    check("burst_rises", rise_t.size(), 4);
    for (int i = 1; i < 4 && i < rise_t.size(); i++) check("burst_spacing", rise_t[i] - rise_t[i-1], F);
    check("burst_peak", int'(max_cnt == 3 || max_cnt == 4), 1);

    // Overflow: fill while the first byte is in flight.
    rise_t.delete();
    drive(8'hA0, 1'b1);
    release_wr();
    wait_rise("ovf_first_rise", 1, 20);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 15) check("ovf_notfull_15", int'(bus.full), 0);
      if (i == 16) begin
        check("ovf_full_16", int'(bus.full), 1);
        check("ovf_count_16", int'(bus.count), 16);
      end
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'hB0 + i);
      if (i < 16) exp_q.push_back(8'(8'hB0 + i));
    end
    release_wr();
    check("ovf_count_after_drop", int'(bus.count), 16);
    check("ovf_full_after_drop", int'(bus.full), 1);
    check("ovf_flag", int'(bus.ovf), int'(EXP_OVF));
    wait_idle("ovf_idle_timeout", 20 * F);
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_rises", rise_t.size(), 17);

    // Pointer wrap: 40 bytes written whenever space is free.
    sent  = 0;
    guard = 0;
    while (sent < 40 && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (!bus.full) begin
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'(8'h40 + sent);
        exp_q.push_back(8'(8'h40 + sent));
        sent++;
      end else begin
        bus.wr_en = 1'b0;
      end
    end
    release_wr();
    check("wrap_all_sent", sent, 40);
    wait_idle("wrap_idle_timeout", 20 * F);
    check("wrap_drained", exp_q.size(), 0);

    // Write coinciding with the pop at the end of LOAD.
    rise_t.delete();
    drive(8'hC1, 1'b1);
    release_wr();
    @(negedge clk);
    check("simul_count_load", int'(bus.count), 1);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hC2;
    exp_q.push_back(8'hC2);
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("simul_count_after", int'(bus.count), 1);
    wait_idle("simul_idle_timeout", 4 * F);
    check("simul_rises", rise_t.size(), 2);
    if (rise_t.size() == 2) check("simul_spacing", rise_t[1] - rise_t[0], F);

    // Reset 100 cycles into a frame.
    rise_t.delete();
    drive(8'h77, 1'b1);
    release_wr();
    wait_rise("rst_first_rise", 1, 20);
    r = (rise_t.size() > 0) ? rise_t[0] : cyc;
    for (int i = 0; i < 200 && cyc < r + 100; i++) @(negedge clk);
    check("rst_busy_before", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;
    single_byte("after_rst", 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
